// File: rtl/super_mem_arbiter.sv
// rtl/super_mem_arbiter.sv - pipeline/loader arbiter for the single-port vector data memory
module super_mem_arbiter #(
    parameter int ELEM_SIZE    = 8,
    parameter int VECT_SIZE    = 8,
    parameter int ADDR_BITS    = 6,
    parameter int STARVE_LIMIT = 4,
    localparam int DW          = ELEM_SIZE * VECT_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 p_req_i,
    input  logic                 p_we_i,
    input  logic [ADDR_BITS-1:0] p_addr_i,
    input  logic [DW-1:0]        p_wdata_i,
    output logic                 p_gnt_o,
    output logic                 p_rvalid_o,
    output logic [DW-1:0]        p_rdata_o,
    output logic                 stall_o,
    input  logic                 l_req_i,
    input  logic                 l_we_i,
    input  logic [ADDR_BITS-1:0] l_addr_i,
    input  logic [DW-1:0]        l_wdata_i,
    output logic                 l_gnt_o,
    output logic                 l_rvalid_o,
    output logic [DW-1:0]        l_rdata_o,
    output logic                 mem_we_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [DW-1:0]        mem_wd_o,
    input  logic [DW-1:0]        mem_rd_i,
    output logic                 starve_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] wait_cnt;
    logic       p_rv_q;
    logic       l_rv_q;
    logic       starve;

    // Grants are held off while reset is asserted so the memory sees no command.
    always_comb begin
        starve  = rst_i && l_req_i && (wait_cnt == LIMIT);
        l_gnt_o = rst_i && l_req_i && (!p_req_i || starve);
        p_gnt_o = rst_i && p_req_i && !l_gnt_o;
    end

    always_comb begin
        mem_we_o   = 1'b0;
        mem_addr_o = '0;
        mem_wd_o   = '0;
        if (l_gnt_o) begin
            mem_we_o   = l_we_i;
            mem_addr_o = l_addr_i;
            mem_wd_o   = l_wdata_i;
        end else if (p_gnt_o) begin
            mem_we_o   = p_we_i;
            mem_addr_o = p_addr_i;
            mem_wd_o   = p_wdata_i;
        end
    end

    assign starve_o = starve;
    assign stall_o  = p_req_i && !p_gnt_o;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wait_cnt <= 4'd0;
        end else if (l_req_i && !l_gnt_o) begin
            if (wait_cnt != LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end else begin
            wait_cnt <= 4'd0;
        end
    end

    // Each rvalid tracks its own requester so alternating reads can return every cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            p_rv_q <= 1'b0;
            l_rv_q <= 1'b0;
        end else begin
            p_rv_q <= p_gnt_o && !p_we_i;
            l_rv_q <= l_gnt_o && !l_we_i;
        end
    end

    assign p_rvalid_o = p_rv_q;
    assign l_rvalid_o = l_rv_q;
    assign p_rdata_o  = p_rv_q ? mem_rd_i : '0;
    assign l_rdata_o  = l_rv_q ? mem_rd_i : '0;

endmodule

// File: tb/tb_super_mem_arbiter.sv
// tb/tb_super_mem_arbiter.sv - directed and random checks of super_mem_arbiter against a reference model
module tb_super_mem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p_req = 1'b1, p_we = 1'b0, l_req = 1'b1, l_we = 1'b0;
    logic [5:0]  p_addr = '0, l_addr = '0;
    logic [63:0] p_wdata = '0, l_wdata = '0;
    logic        p_gnt, p_rvalid, stall, l_gnt, l_rvalid, mem_we, starve;
    logic [63:0] p_rdata, l_rdata, mem_wd, mem_rd;
    logic [5:0]  mem_addr;

    super_mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk_i(clk), .rst_i(rst),
        .p_req_i(p_req), .p_we_i(p_we), .p_addr_i(p_addr), .p_wdata_i(p_wdata),
        .p_gnt_o(p_gnt), .p_rvalid_o(p_rvalid), .p_rdata_o(p_rdata), .stall_o(stall),
        .l_req_i(l_req), .l_we_i(l_we), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
        .l_gnt_o(l_gnt), .l_rvalid_o(l_rvalid), .l_rdata_o(l_rdata),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd),
        .starve_o(starve)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input int a);
        if (a == 5) return 64'hA5A5_A5A5_A5A5_A5A5;
        return {8{8'(a)}} ^ 64'h0F1E_2D3C_4B5A_6978;
    endfunction

    // Single-port memory with a registered (1-cycle) read.
    logic [63:0] tb_mem [64];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= init_word(i);
            mem_ready <= 1'b1;
            mem_rd    <= '0;
        end else begin
            if (mem_we) tb_mem[mem_addr] <= mem_wd;
            mem_rd <= tb_mem[mem_addr];
        end
    end

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] ref_mem [64];
    int          denied = 0;
    logic        exp_prv = 1'b0, exp_lrv = 1'b0;
    logic [63:0] exp_prd = '0, exp_lrd = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, then advance the model past the edge.
    task automatic step(input logic r, input logic pr, input logic pw, input logic [5:0] pa,
                        input logic [63:0] pd, input logic lr, input logic lw,
                        input logic [5:0] la, input logic [63:0] ld);
        bit          win_l, win_p;
        logic        ewe;
        logic [5:0]  ea;
        logic [63:0] ed;
        @(negedge clk);
        rst = r; p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
        #1;
        win_l = r && lr && (!pr || denied >= LIM);
        win_p = r && pr && !win_l;
        ewe = 1'b0; ea = '0; ed = '0;
        if (win_l) begin ewe = lw; ea = la; ed = ld; end
        else if (win_p) begin ewe = pw; ea = pa; ed = pd; end
        chk("p_gnt", 64'(p_gnt), 64'(win_p));
        chk("l_gnt", 64'(l_gnt), 64'(win_l));
        chk("stall", 64'(stall), 64'(pr && !win_p));
        chk("starve", 64'(starve), 64'(r && lr && denied >= LIM));
        chk("mem_we", 64'(mem_we), 64'(ewe));
        chk("mem_addr", 64'(mem_addr), 64'(ea));
        chk("mem_wd", mem_wd, ed);
        chk("p_rvalid", 64'(p_rvalid), 64'(exp_prv));
        chk("p_rdata", p_rdata, exp_prv ? exp_prd : 64'd0);
        chk("l_rvalid", 64'(l_rvalid), 64'(exp_lrv));
        chk("l_rdata", l_rdata, exp_lrv ? exp_lrd : 64'd0);
        if (!r) begin
            denied = 0; exp_prv = 1'b0; exp_lrv = 1'b0;
        end else begin
            exp_prv = win_p && !pw;
            exp_lrv = win_l && !lw;
            exp_prd = ref_mem[pa];
            exp_lrd = ref_mem[la];
            if (ewe) ref_mem[ea] = ed;
            denied = (lr && !win_l) ? ((denied < LIM) ? denied + 1 : LIM) : 0;
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0);
    endtask

    task automatic both(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b1, 1'($urandom_range(1)), 6'($urandom), {$urandom, $urandom},
                 1'b1, 1'($urandom_range(1)), 6'($urandom), {$urandom, $urandom});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        // Reset held with both requests high, then release.
        step(1'b0, 1'b1, 1'b0, 6'd1, 64'd0, 1'b1, 1'b0, 6'd2, 64'd0);
        step(1'b0, 1'b1, 1'b0, 6'd1, 64'd0, 1'b1, 1'b0, 6'd2, 64'd0);
        step(1'b1, 1'b1, 1'b0, 6'd1, 64'd0, 1'b1, 1'b0, 6'd2, 64'd0);
        idle();
        // Solo pipeline read of the preloaded line.
        step(1'b1, 1'b1, 1'b0, 6'd5, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0);
        idle();
        // Continuous contention: P,P,P,P,L repeating.
        both(12);
        idle();
        // Loader write then pipeline read-after-write.
        step(1'b1, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b1, 6'd63, 64'h1122334455667788);
        step(1'b1, 1'b1, 1'b0, 6'd63, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0);
        idle();
        // Alternating back-to-back reads.
        step(1'b1, 1'b1, 1'b0, 6'd7, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0);
        step(1'b1, 1'b0, 1'b0, 6'd0, 64'd0, 1'b1, 1'b0, 6'd9, 64'd0);
        step(1'b1, 1'b1, 1'b0, 6'd63, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0);
        // Reset arriving behind a granted read discards the return.
        step(1'b1, 1'b1, 1'b0, 6'd5, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0);
        step(1'b0, 1'b1, 1'b0, 6'd5, 64'd0, 1'b1, 1'b0, 6'd3, 64'd0);
        idle();
        // Loader drops after 3 denials; count restarts.
        both(3);
        step(1'b1, 1'b1, 1'b0, 6'd4, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0);
        both(6);
        // Loader drops exactly while starved.
        both(4);
        step(1'b1, 1'b1, 1'b0, 6'd4, 64'd0, 1'b0, 1'b0, 6'd0, 64'd0);
        both(2);
        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(39) != 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 6'($urandom_range(7)), {$urandom, $urandom},
                 ($urandom_range(3) != 0), 1'($urandom_range(1)),
                 6'($urandom_range(7)), {$urandom, $urandom});
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
